// File: rtl/nn_sched_pkg.sv
//------------------------------------------------------------------------------
// nn_sched_pkg : shared state encoding, layer ids and width helpers
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package nn_sched_pkg;

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_CLR   = 3'd1;
  localparam logic [2:0] c_S_FETCH = 3'd2;
  localparam logic [2:0] c_S_MAC   = 3'd3;
  localparam logic [2:0] c_S_ACT   = 3'd4;
  localparam logic [2:0] c_S_WRITE = 3'd5;
  localparam logic [2:0] c_S_DONE  = 3'd6;

  localparam logic LAYER_HID = 1'b0;
  localparam logic LAYER_OUT = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Keeps every derived bus at least one bit wide for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/index_counter.sv
//------------------------------------------------------------------------------
// index_counter : up-counter with synchronous init, increment and terminal count
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module index_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_init,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_init) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_last);

endmodule

`default_nettype wire

// File: rtl/layer_scheduler.sv
//------------------------------------------------------------------------------
// layer_scheduler : sequences fetch/MAC/activate/write for a two-layer network
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter  int N_IN  = 8,
  parameter  int N_HID = 4,
  parameter  int N_OUT = 2,
  localparam int IW    = clog2_min1(max2(N_IN, N_HID)),
  localparam int NW    = clog2_min1(max2(N_HID, N_OUT)),
  localparam int AW    = clog2_min1(N_IN * N_HID + N_HID * N_OUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_rd_valid,
  output logic          o_rd_en,
  output logic [IW-1:0] o_in_addr,
  output logic [AW-1:0] o_w_addr,
  output logic          o_layer,
  output logic          o_clr_acc,
  output logic          o_mac_en,
  output logic          o_act_en,
  output logic          o_wr_en,
  output logic [NW-1:0] o_wr_addr,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [IW-1:0] c_IDX_LAST0 = IW'(N_IN - 1);
  localparam logic [IW-1:0] c_IDX_LAST1 = IW'(N_HID - 1);
  localparam logic [NW-1:0] c_NEU_LAST0 = NW'(N_HID - 1);
  localparam logic [NW-1:0] c_NEU_LAST1 = NW'(N_OUT - 1);
  localparam logic [AW-1:0] c_BASE1     = AW'(N_IN * N_HID);
  localparam logic [AW-1:0] c_FANIN0    = AW'(N_IN);
  localparam logic [AW-1:0] c_FANIN1    = AW'(N_HID);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic          r_layer;
  logic          w_abort;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_idx_last;
  logic          w_idx_tc;
  logic          w_idx_init;
  logic          w_idx_inc;
  logic [NW-1:0] w_neu;
  logic [NW-1:0] w_neu_last;
  logic          w_neu_tc;
  logic          w_neu_init;
  logic          w_neu_inc;
  logic [AW-1:0] w_addr_calc;

  assign w_abort    = i_abort && (r_state != c_S_IDLE);
  assign w_idx_last = (r_layer == LAYER_OUT) ? c_IDX_LAST1 : c_IDX_LAST0;
  assign w_neu_last = (r_layer == LAYER_OUT) ? c_NEU_LAST1 : c_NEU_LAST0;

  assign w_idx_init = w_abort || (r_state == c_S_IDLE) || (r_state == c_S_CLR);
  assign w_idx_inc  = (r_state == c_S_MAC) && !w_idx_tc;
  // Neuron index wraps to 0 both at the layer switch and at the end of the run.
  assign w_neu_init = w_abort || (r_state == c_S_IDLE) || ((r_state == c_S_WRITE) && w_neu_tc);
  assign w_neu_inc  = (r_state == c_S_WRITE) && !w_neu_tc;

  index_counter #(.W(IW)) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_init  (w_idx_init),
    .i_inc   (w_idx_inc),
    .i_last  (w_idx_last),
    .o_count (w_idx),
    .o_tc    (w_idx_tc)
  );

  index_counter #(.W(NW)) u_neuron (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_init  (w_neu_init),
    .i_inc   (w_neu_inc),
    .i_last  (w_neu_last),
    .o_count (w_neu),
    .o_tc    (w_neu_tc)
  );

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = c_S_IDLE;
    end else begin
      case (r_state)
        c_S_IDLE:  if (i_start) w_next = c_S_CLR;
        c_S_CLR:   w_next = c_S_FETCH;
        c_S_FETCH: if (i_rd_valid) w_next = c_S_MAC;
        c_S_MAC:   w_next = w_idx_tc ? c_S_ACT : c_S_FETCH;
        c_S_ACT:   w_next = c_S_WRITE;
        c_S_WRITE: w_next = (w_neu_tc && (r_layer == LAYER_OUT)) ? c_S_DONE : c_S_CLR;
        c_S_DONE:  w_next = c_S_IDLE;
        default:   w_next = c_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_layer <= LAYER_HID;
    end else begin
      r_state <= w_next;
      if (w_next == c_S_IDLE) begin
        r_layer <= LAYER_HID;
      end else if ((r_state == c_S_WRITE) && w_neu_tc && (r_layer == LAYER_HID)) begin
        r_layer <= LAYER_OUT;
      end
    end
  end

  assign w_addr_calc = ((r_layer == LAYER_OUT) ? c_BASE1 : '0)
                     + AW'(w_neu) * ((r_layer == LAYER_OUT) ? c_FANIN1 : c_FANIN0)
                     + AW'(w_idx);

  assign o_rd_en   = (r_state == c_S_FETCH);
  assign o_in_addr = o_rd_en ? w_idx : '0;
  assign o_w_addr  = o_rd_en ? w_addr_calc : '0;
  assign o_layer   = r_layer;
  assign o_clr_acc = (r_state == c_S_CLR);
  assign o_mac_en  = (r_state == c_S_MAC);
  assign o_act_en  = (r_state == c_S_ACT);
  assign o_wr_en   = (r_state == c_S_WRITE);
  assign o_wr_addr = o_wr_en ? w_neu : '0;
  assign o_busy    = (r_state != c_S_IDLE);
  assign o_done    = (r_state == c_S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_layer_scheduler.sv
//------------------------------------------------------------------------------
// tb_layer_scheduler : directed and randomized-stall runs against a transaction model
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_layer_scheduler;

  localparam int N_IN  = 8;
  localparam int N_HID = 4;
  localparam int N_OUT = 2;
  localparam int IW    = 3;
  localparam int NW    = 2;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_en;
  logic [IW-1:0] in_addr;
  logic [AW-1:0] w_addr;
  logic          layer;
  logic          clr_acc;
  logic          mac_en;
  logic          act_en;
  logic          wr_en;
  logic [NW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int lyr;
    int ia;
    int wa;
  } fetch_t;

  fetch_t fq[$];
  int     wn[$];
  int     wl[$];

  always #5 clk = ~clk;

  layer_scheduler #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .i_rd_valid (rd_valid),
    .o_rd_en    (rd_en),
    .o_in_addr  (in_addr),
    .o_w_addr   (w_addr),
    .o_layer    (layer),
    .o_clr_acc  (clr_acc),
    .o_mac_en   (mac_en),
    .o_act_en   (act_en),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {rd_en, in_addr, w_addr, layer, clr_acc, mac_en, act_en, wr_en,
                wr_addr, busy, done}, '0);
  endtask

  // Expected fetch/write transactions derived from the layer table.
  function automatic void build_model();
    fq.delete();
    wn.delete();
    wl.delete();
    for (int l = 0; l < 2; l++) begin
      int fin;
      int fout;
      int base;
      fin  = (l == 1) ? N_HID : N_IN;
      fout = (l == 1) ? N_OUT : N_HID;
      base = (l == 1) ? N_IN * N_HID : 0;
      for (int n = 0; n < fout; n++) begin
        for (int i = 0; i < fin; i++) fq.push_back('{l, i, base + n * fin + i});
        wl.push_back(l);
        wn.push_back(n);
      end
    end
  endfunction

  task automatic run(input string name, input int pct, input int first_stall,
                     input bit repulse, input bit do_abort, input int rst_at_mac);
    int  stalls;
    int  macs;
    int  wrs;
    int  fs;
    bit  pend;
    bit  fin;
    fetch_t f;
    build_model();
    stalls = 0; macs = 0; wrs = 0; fs = first_stall; pend = 0; fin = 0;
    @(negedge clk);
    start    = 1'b1;
    rd_valid = 1'b1;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      start = (repulse && cyc == 10);
      check({name, "/onehot"}, 64'($countones({clr_acc, mac_en, act_en, wr_en}) <= 1), 1);
      check({name, "/busy"}, busy, 1);
      check({name, "/mac"}, mac_en, pend);
      if (mac_en) macs++;
      pend = 0;
      if (rd_en) begin
        if (fq.size() == 0) begin
          check({name, "/extra_fetch"}, 1, 0);
        end else begin
          f = fq[0];
          check({name, "/in_addr"}, in_addr, f.ia);
          check({name, "/w_addr"}, w_addr, f.wa);
          check({name, "/fetch_layer"}, layer, f.lyr);
          if (fs > 0) begin
            rd_valid = 1'b0; fs--; stalls++;
          end else if (pct > 0 && $urandom_range(99) < pct) begin
            rd_valid = 1'b0; stalls++;
          end else begin
            rd_valid = 1'b1; void'(fq.pop_front()); pend = 1;
          end
        end
      end else begin
        rd_valid = (pct > 0) ? 1'($urandom_range(1)) : 1'b1;
      end
      if (wr_en) begin
        if (wn.size() == 0) begin
          check({name, "/extra_write"}, 1, 0);
        end else begin
          check({name, "/wr_addr"}, wr_addr, wn.pop_front());
          check({name, "/wr_layer"}, layer, wl.pop_front());
          wrs++;
        end
      end
      if (done) begin
        check({name, "/done_edge"}, cyc, 99 + stalls);
        fin = 1;
      end
      if (do_abort && clr_acc && layer) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_zero({name, "/after_abort"});
        @(negedge clk);
        check_zero({name, "/idle_after_abort"});
        return;
      end
      if (rst_at_mac >= 0 && mac_en && macs == rst_at_mac) begin
        #2 rst_n = 1'b0;
        #1 check_zero({name, "/async_reset"});
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check_zero({name, "/idle_after_reset"});
        end
        return;
      end
    end
    if (!fin) check({name, "/timeout"}, 0, 1);
    check({name, "/mac_count"}, macs, N_IN * N_HID + N_HID * N_OUT);
    check({name, "/wr_count"}, wrs, N_HID + N_OUT);
    check({name, "/fetch_left"}, fq.size(), 0);
    @(negedge clk);
    check_zero({name, "/idle_after_done"});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle_no_start");

    run("base",      0, 0, 1'b0, 1'b0, -1);
    run("stall3",    0, 3, 1'b0, 1'b0, -1);
    run("repulse",   0, 0, 1'b1, 1'b0, -1);
    run("abort",     0, 0, 1'b0, 1'b1, -1);
    run("post_abort", 0, 0, 1'b0, 1'b0, -1);
    run("rst_mid",   0, 0, 1'b0, 1'b0, 5);
    run("post_rst",  0, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 4; r++) run($sformatf("rand%0d", r), 40, 0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter N_IN, default 8, input-vector length, which is layer-0 fan-in.
REQ-002 Parameter N_HID, default 4, hidden-neuron count, which is layer-0 fan-out and layer-1 fan-in.
REQ-003 Parameter N_OUT, default 2, output-neuron count, which is layer-1 fan-out.
REQ-004 Derived widths: IW=$clog2(max(N_IN,N_HID)), NW=$clog2(max(N_HID,N_OUT)), AW=$clog2(N_IN*N_HID+N_HID*N_OUT).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset. Ports:
 clk  in  1  single clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 start  in  1  begin inference; sampled in IDLE only
 abort  in  1  synchronous cancel
 rd_valid  in  1  input/weight read data valid for the current FETCH
 rd_en  out  1  read request for input and weight
 in_addr  out  IW  input index (layer 0: input memory; layer 1: hidden buffer)
 w_addr  out  AW  flat weight address
 layer  out  1  0 = hidden layer, 1 = output layer
 clr_acc  out  1  clear the neuron accumulator
 mac_en  out  1  accumulate the current product
 act_en  out  1  apply the activation function to the accumulator
 wr_en  out  1  write the activated result
 wr_addr  out  NW  destination neuron index
 busy  out  1  high in every state except IDLE
 done  out  1  one-cycle completion pulse

Function
REQ-006 The block SHALL implement an FSM with states IDLE, CLR, FETCH, MAC, ACT, WRITE and DONE; all outputs SHALL be Moore-decoded from the state and the counters.
REQ-007 IDLE: if start=1, go to CLR with layer=0, neuron=0, idx=0; otherwise stay.
REQ-008 CLR: clr_acc=1 for exactly one cycle, idx cleared, then go to FETCH.
REQ-009 FETCH: rd_en=1, in_addr=idx, w_addr=base(layer)+neuron*fanin(layer)+idx.
 Go to MAC when rd_valid=1; hold in FETCH with address stable while rd_valid=0.
REQ-010 MAC: mac_en=1 for one cycle. If idx==fanin-1, go to ACT; otherwise idx+1 and go to FETCH.
REQ-011 ACT: act_en=1 for one cycle, then go to WRITE.
REQ-012 WRITE: wr_en=1, wr_addr=neuron. Next state:
 - neuron<fanout-1: neuron+1, go to CLR.
 - last neuron of layer 0: layer=1, neuron=0, go to CLR.
 - last neuron of layer 1: go to DONE.
REQ-013 DONE: done=1 for one cycle, then go to IDLE.
REQ-014 Layer parameters:
 - layer 0: fanin=N_IN, fanout=N_HID, base=0.
 - layer 1: fanin=N_HID, fanout=N_OUT, base=N_IN*N_HID.
REQ-015 Width rule: w_addr SHALL be computed at AW bits with no truncation; the maximum address is N_IN*N_HID+N_HID*N_OUT-1.
REQ-016 start SHALL be ignored while busy=1; start held high continuously SHALL restart the sequence only after DONE returns to IDLE.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse and all strobes low; abort has priority over every other transition, including DONE. abort in IDLE has no effect.
REQ-018 At most one of clr_acc, mac_en, act_en and wr_en SHALL be high in any cycle.

Reset
REQ-019 When rst=0: state=IDLE, layer=0, neuron=0, idx=0, and every output is 0 (in_addr, w_addr and wr_addr = 0).
REQ-020 Reset asserted mid-operation SHALL abandon the run immediately with no done pulse; after release the block waits for a new start.

Structure
REQ-021 Shared package nn_sched_pkg SHALL hold the state encoding constants and the LAYER_HID/LAYER_OUT constants.
REQ-022 One sub-module, index_counter: a parameterised up-counter with init, inc and terminal-count output, instantiated for idx and for neuron.

Verification
REQ-023 Defaults, rd_valid tied to 1, one start pulse:
 - 40 mac_en pulses, 6 wr_en pulses (wr_addr 0..3, then 0..1).
 - done high on the 99th edge, counting the start-sampling edge as edge 1.
REQ-024 Defaults: first layer-1 FETCH shows w_addr=32, in_addr=0; the last FETCH shows w_addr=39, in_addr=3.
REQ-025 rd_valid=0 for 3 cycles during the first FETCH: rd_en stays high and w_addr stays at 0; mac_en occurs only after rd_valid=1; total run length grows by 3 cycles.
REQ-026 start re-pulsed at cycle 10 of a run: no effect, and the results are identical to REQ-023.
REQ-027 abort at the first layer-1 CLR: IDLE next cycle, busy=0, no done pulse; a new start then reproduces REQ-023.
REQ-028 rst=0 during a MAC cycle: all outputs 0 asynchronously; after release the block stays idle until start.
